// File: rtl/fifo_pkg.sv
// Shared constants for the DMA FIFO word control stage.
// Direction encoding and big-endian byte-lane one-hots.
package fifo_pkg;

    localparam logic DIR_TO_MEM   = 1'b0;
    localparam logic DIR_FROM_MEM = 1'b1;

    localparam logic [1:0] LANE_LAST = 2'd3;

    localparam logic [3:0] LANE0_OH = 4'b1000;
    localparam logic [3:0] LANE1_OH = 4'b0100;
    localparam logic [3:0] LANE2_OH = 4'b0010;
    localparam logic [3:0] LANE3_OH = 4'b0001;

endpackage

// File: rtl/fifo_lane_dec.sv
// Byte-lane write enable decoder.
// Lane 0 is bits 31:24 and maps to enable bit 3.
module fifo_lane_dec
    import fifo_pkg::*;
(
    input  logic [1:0] ptr,
    input  logic       en,
    output logic [3:0] lane_we
);

    // one-hot of the byte pointer, gated by the enable
    always_comb begin
        lane_we = 4'b0000;
        if (en) begin
            unique case (ptr)
                2'd0: lane_we = LANE0_OH;
                2'd1: lane_we = LANE1_OH;
                2'd2: lane_we = LANE2_OH;
                2'd3: lane_we = LANE3_OH;
            endcase
        end
    end

endmodule

// File: rtl/fifo_word_ctrl.sv
// Word-level control for the DMA FIFO: pointers, occupancy,
// partial-word tracking, lane enables and sticky error flags.
module fifo_word_ctrl
    import fifo_pkg::*;
#(
    parameter int AW = 3
) (
    input  logic          CLK,
    input  logic          RST_FIFO_,
    input  logic          DIR,
    input  logic [1:0]    PTR,
    input  logic          BYTE_STB,
    input  logic          WORD_WR,
    input  logic          WORD_RD,
    input  logic          FLUSH,
    input  logic          CLR_ERR,
    output logic [3:0]    LANE_WE,
    output logic [AW-1:0] WR_ADDR,
    output logic [AW-1:0] RD_ADDR,
    output logic          INCBO,
    output logic [AW:0]   COUNT,
    output logic          FULL,
    output logic          EMPTY,
    output logic          PARTIAL,
    output logic          OVF,
    output logic          UNF
);

    localparam int          DEPTH    = 2 ** AW;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ONE_CNT  = (AW + 1)'(1);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          partial;
    logic          ovf;
    logic          unf;

    logic to_mem;
    logic from_mem;
    logic last;
    logic byte_wr;
    logic byte_rd;
    logic word_wr;
    logic word_rd;
    logic flush_act;
    logic wr_commit;
    logic rd_commit;
    logic ovf_set;
    logic unf_set;
    logic [3:0] lane_byte;

    assign FULL     = (count == FULL_CNT);
    assign EMPTY    = (count == '0);
    assign to_mem   = (DIR == DIR_TO_MEM);
    assign from_mem = (DIR == DIR_FROM_MEM);
    assign last     = (PTR == LANE_LAST);

    assign byte_wr = BYTE_STB & to_mem & ~FULL;
    assign byte_rd = BYTE_STB & from_mem & ~EMPTY;
    assign word_wr = WORD_WR & from_mem & ~FULL;
    assign word_rd = WORD_RD & to_mem & ~EMPTY;

    // a flush only commits when some byte of the slot is live
    assign flush_act = FLUSH & to_mem & ~FULL
                     & (partial | (byte_wr & ~last));

    // a final byte and a flush in the same cycle are one commit
    assign wr_commit = (byte_wr & last) | word_wr | flush_act;
    assign rd_commit = (byte_rd & last) | word_rd;

    assign ovf_set = FULL & ((BYTE_STB & to_mem)
                           | (WORD_WR & from_mem)
                           | (FLUSH & to_mem & partial));
    assign unf_set = EMPTY & ((BYTE_STB & from_mem)
                            | (WORD_RD & to_mem));

    fifo_lane_dec u_lane_dec (
        .ptr     (PTR),
        .en      (byte_wr),
        .lane_we (lane_byte)
    );

    assign LANE_WE = lane_byte | {4{word_wr}};
    assign INCBO   = byte_wr | byte_rd;
    assign WR_ADDR = wr_ptr;
    assign RD_ADDR = rd_ptr;
    assign COUNT   = count;
    assign PARTIAL = partial;
    assign OVF     = ovf;
    assign UNF     = unf;

    // pointer, occupancy, partial-word and error flag state
    always_ff @(posedge CLK or negedge RST_FIFO_) begin
        if (!RST_FIFO_) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            partial <= 1'b0;
            ovf     <= 1'b0;
            unf     <= 1'b0;
        end else begin
            if (wr_commit)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_commit)
                rd_ptr <= rd_ptr + 1'b1;
            if (wr_commit && !rd_commit)
                count <= count + ONE_CNT;
            else if (rd_commit && !wr_commit)
                count <= count - ONE_CNT;
            if ((byte_wr && last) || flush_act)
                partial <= 1'b0;
            else if (byte_wr)
                partial <= 1'b1;
            if (ovf_set)
                ovf <= 1'b1;
            else if (CLR_ERR)
                ovf <= 1'b0;
            if (unf_set)
                unf <= 1'b1;
            else if (CLR_ERR)
                unf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_word_ctrl.sv
// Directed self-checking bench for fifo_word_ctrl.
// Inputs change 1ns after the rising edge; outputs sampled mid-cycle.
module tb_fifo_word_ctrl;

    localparam int AW = 3;

    logic          CLK;
    logic          RST_FIFO_;
    logic          DIR;
    logic [1:0]    PTR;
    logic          BYTE_STB;
    logic          WORD_WR;
    logic          WORD_RD;
    logic          FLUSH;
    logic          CLR_ERR;
    logic [3:0]    LANE_WE;
    logic [AW-1:0] WR_ADDR;
    logic [AW-1:0] RD_ADDR;
    logic          INCBO;
    logic [AW:0]   COUNT;
    logic          FULL;
    logic          EMPTY;
    logic          PARTIAL;
    logic          OVF;
    logic          UNF;

    int vecs;
    int errs;

    fifo_word_ctrl #(.AW(AW)) dut (
        .CLK       (CLK),
        .RST_FIFO_ (RST_FIFO_),
        .DIR       (DIR),
        .PTR       (PTR),
        .BYTE_STB  (BYTE_STB),
        .WORD_WR   (WORD_WR),
        .WORD_RD   (WORD_RD),
        .FLUSH     (FLUSH),
        .CLR_ERR   (CLR_ERR),
        .LANE_WE   (LANE_WE),
        .WR_ADDR   (WR_ADDR),
        .RD_ADDR   (RD_ADDR),
        .INCBO     (INCBO),
        .COUNT     (COUNT),
        .FULL      (FULL),
        .EMPTY     (EMPTY),
        .PARTIAL   (PARTIAL),
        .OVF       (OVF),
        .UNF       (UNF)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic idle();
        BYTE_STB = 1'b0;
        WORD_WR  = 1'b0;
        WORD_RD  = 1'b0;
        FLUSH    = 1'b0;
        CLR_ERR  = 1'b0;
        PTR      = 2'd0;
    endtask

    // finish the current cycle and land 1ns after the next edge
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset(input logic dir);
        idle();
        RST_FIFO_ = 1'b0;
        DIR = dir;
        tick();
        RST_FIFO_ = 1'b1;
    endtask

    task automatic byte_cycle(input logic [1:0] p);
        PTR = p;
        BYTE_STB = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        #2;
        vecs++;
        if (EMPTY !== 1'b1 || FULL !== 1'b0 || COUNT !== 4'd0) begin
            errs++;
            $display("FAIL reset_flags got E=%b F=%b C=%0d exp E=1 F=0 C=0",
                     EMPTY, FULL, COUNT);
        end
        vecs++;
        if (LANE_WE !== 4'h0 || INCBO !== 1'b0 || PARTIAL !== 1'b0 ||
            OVF !== 1'b0 || UNF !== 1'b0) begin
            errs++;
            $display("FAIL reset_outs got WE=%h I=%b P=%b O=%b U=%b exp all 0",
                     LANE_WE, INCBO, PARTIAL, OVF, UNF);
        end
        vecs++;
        if (WR_ADDR !== 3'd0 || RD_ADDR !== 3'd0) begin
            errs++;
            $display("FAIL reset_ptrs got W=%0d R=%0d exp 0 0",
                     WR_ADDR, RD_ADDR);
        end
        tick();
    endtask

    task automatic test_byte_lanes();
        logic [3:0] exp_we [4] = '{4'h8, 4'h4, 4'h2, 4'h1};
        logic       exp_p  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        do_reset(1'b0);
        for (int i = 0; i < 4; i++) begin
            PTR = 2'(i);
            BYTE_STB = 1'b1;
            #2;
            vecs++;
            if (LANE_WE !== exp_we[i] || INCBO !== 1'b1 || WR_ADDR !== 3'd0) begin
                errs++;
                $display("FAIL byte_lane%0d got WE=%h I=%b WA=%0d exp WE=%h I=1 WA=0",
                         i, LANE_WE, INCBO, WR_ADDR, exp_we[i]);
            end
            tick();
            idle();
            vecs++;
            if (PARTIAL !== exp_p[i] || COUNT !== ((i == 3) ? 4'd1 : 4'd0)) begin
                errs++;
                $display("FAIL byte_state%0d got P=%b C=%0d exp P=%b C=%0d",
                         i, PARTIAL, COUNT, exp_p[i], (i == 3) ? 1 : 0);
            end
        end
        vecs++;
        if (WR_ADDR !== 3'd1 || EMPTY !== 1'b0) begin
            errs++;
            $display("FAIL byte_wraddr got WA=%0d E=%b exp WA=1 E=0",
                     WR_ADDR, EMPTY);
        end
    endtask

    task automatic test_odd_start_flush();
        logic [1:0] seq [8] = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        do_reset(1'b0);
        foreach (seq[i]) byte_cycle(seq[i]);
        vecs++;
        if (COUNT !== 4'd2 || PARTIAL !== 1'b1) begin
            errs++;
            $display("FAIL odd_prefl got C=%0d P=%b exp C=2 P=1", COUNT, PARTIAL);
        end
        FLUSH = 1'b1;
        #2;
        vecs++;
        if (INCBO !== 1'b0 || LANE_WE !== 4'h0) begin
            errs++;
            $display("FAIL flush_pulse got I=%b WE=%h exp I=0 WE=0",
                     INCBO, LANE_WE);
        end
        tick();
        idle();
        vecs++;
        if (COUNT !== 4'd3 || PARTIAL !== 1'b0 || WR_ADDR !== 3'd3) begin
            errs++;
            $display("FAIL flush_commit got C=%0d P=%b WA=%0d exp C=3 P=0 WA=3",
                     COUNT, PARTIAL, WR_ADDR);
        end
        FLUSH = 1'b1;
        tick();
        idle();
        vecs++;
        if (COUNT !== 4'd3 || WR_ADDR !== 3'd3) begin
            errs++;
            $display("FAIL flush_noop got C=%0d WA=%0d exp C=3 WA=3",
                     COUNT, WR_ADDR);
        end
        PTR = 2'd1;
        BYTE_STB = 1'b1;
        FLUSH = 1'b1;
        tick();
        idle();
        vecs++;
        if (COUNT !== 4'd4 || PARTIAL !== 1'b0 || WR_ADDR !== 3'd4) begin
            errs++;
            $display("FAIL flush_byte got C=%0d P=%b WA=%0d exp C=4 P=0 WA=4",
                     COUNT, PARTIAL, WR_ADDR);
        end
        PTR = 2'd3;
        BYTE_STB = 1'b1;
        FLUSH = 1'b1;
        tick();
        idle();
        vecs++;
        if (COUNT !== 4'd5 || WR_ADDR !== 3'd5) begin
            errs++;
            $display("FAIL flush_last got C=%0d WA=%0d exp C=5 WA=5",
                     COUNT, WR_ADDR);
        end
    endtask

    task automatic test_full_ovf();
        do_reset(1'b1);
        for (int i = 0; i < 8; i++) begin
            WORD_WR = 1'b1;
            #2;
            vecs++;
            if (LANE_WE !== 4'hF || WR_ADDR !== 3'(i)) begin
                errs++;
                $display("FAIL wordwr%0d got WE=%h WA=%0d exp WE=f WA=%0d",
                         i, LANE_WE, WR_ADDR, i);
            end
            tick();
            idle();
        end
        vecs++;
        if (FULL !== 1'b1 || COUNT !== 4'd8 || WR_ADDR !== 3'd0) begin
            errs++;
            $display("FAIL full got F=%b C=%0d WA=%0d exp F=1 C=8 WA=0",
                     FULL, COUNT, WR_ADDR);
        end
        WORD_WR = 1'b1;
        #2;
        vecs++;
        if (LANE_WE !== 4'h0) begin
            errs++;
            $display("FAIL ovf_we got WE=%h exp 0", LANE_WE);
        end
        tick();
        idle();
        vecs++;
        if (OVF !== 1'b1 || COUNT !== 4'd8 || UNF !== 1'b0) begin
            errs++;
            $display("FAIL ovf_set got O=%b C=%0d U=%b exp O=1 C=8 U=0",
                     OVF, COUNT, UNF);
        end
        CLR_ERR = 1'b1;
        tick();
        idle();
        vecs++;
        if (OVF !== 1'b0) begin
            errs++;
            $display("FAIL ovf_clr got O=%b exp 0", OVF);
        end
    endtask

    task automatic test_back_to_back();
        do_reset(1'b1);
        WORD_WR = 1'b1;
        tick();
        idle();
        WORD_WR = 1'b1;
        BYTE_STB = 1'b1;
        PTR = 2'd3;
        #2;
        vecs++;
        if (INCBO !== 1'b1 || LANE_WE !== 4'hF) begin
            errs++;
            $display("FAIL b2b_comb got I=%b WE=%h exp I=1 WE=f",
                     INCBO, LANE_WE);
        end
        tick();
        idle();
        vecs++;
        if (COUNT !== 4'd1 || RD_ADDR !== 3'd1 || WR_ADDR !== 3'd2) begin
            errs++;
            $display("FAIL b2b_state got C=%0d RA=%0d WA=%0d exp C=1 RA=1 WA=2",
                     COUNT, RD_ADDR, WR_ADDR);
        end
    endtask

    task automatic test_underflow();
        do_reset(1'b0);
        WORD_RD = 1'b1;
        WORD_WR = 1'b1;
        #2;
        vecs++;
        if (LANE_WE !== 4'h0) begin
            errs++;
            $display("FAIL inactive_wr got WE=%h exp 0", LANE_WE);
        end
        tick();
        idle();
        vecs++;
        if (UNF !== 1'b1 || RD_ADDR !== 3'd0 || OVF !== 1'b0 || COUNT !== 4'd0) begin
            errs++;
            $display("FAIL unf_set got U=%b RA=%0d O=%b C=%0d exp U=1 RA=0 O=0 C=0",
                     UNF, RD_ADDR, OVF, COUNT);
        end
        WORD_RD = 1'b1;
        CLR_ERR = 1'b1;
        tick();
        idle();
        vecs++;
        if (UNF !== 1'b1) begin
            errs++;
            $display("FAIL unf_setwins got U=%b exp 1", UNF);
        end
        CLR_ERR = 1'b1;
        tick();
        idle();
        vecs++;
        if (UNF !== 1'b0) begin
            errs++;
            $display("FAIL unf_clr got U=%b exp 0", UNF);
        end
    endtask

    task automatic test_reset_mid();
        do_reset(1'b0);
        for (int w = 0; w < 6; w++)
            for (int b = 0; b < 4; b++)
                byte_cycle(2'(b));
        WORD_RD = 1'b1;
        tick();
        idle();
        byte_cycle(2'd0);
        vecs++;
        if (COUNT !== 4'd5 || PARTIAL !== 1'b1 || RD_ADDR !== 3'd1 ||
            WR_ADDR !== 3'd6) begin
            errs++;
            $display("FAIL mid_pre got C=%0d P=%b RA=%0d WA=%0d exp C=5 P=1 RA=1 WA=6",
                     COUNT, PARTIAL, RD_ADDR, WR_ADDR);
        end
        RST_FIFO_ = 1'b0;
        #1;
        vecs++;
        if (COUNT !== 4'd0 || PARTIAL !== 1'b0 || EMPTY !== 1'b1 ||
            RD_ADDR !== 3'd0 || WR_ADDR !== 3'd0) begin
            errs++;
            $display("FAIL mid_rst got C=%0d P=%b E=%b RA=%0d WA=%0d exp 0 0 1 0 0",
                     COUNT, PARTIAL, EMPTY, RD_ADDR, WR_ADDR);
        end
        tick();
        RST_FIFO_ = 1'b1;
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        idle();
        DIR = 1'b0;
        RST_FIFO_ = 1'b0;
        #3;
        test_reset();
        test_byte_lanes();
        test_odd_start_flush();
        test_full_ovf();
        test_back_to_back();
        test_underflow();
        test_reset_mid();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
